muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit sitting between the register-file read ports and the register-file write port. Accepts two operands (rd1/rd2 values) plus a destination register index, computes one of the eight RV32M operations over a fixed 33-cycle latency, and presents a registered result with a write-enable and address ready to drive we3/a3/wd3 of the register file. One operation in flight at a time; start/busy/done handshake.

---
 rtl/muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_muldiv_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide steps,
// with sign fix-up and special-case overrides applied on the edge entering DONE.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic        wb_we
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [2:0]  op_q;
  logic [31:0] opnd_q;
  logic [63:0] acc_q;
  logic [32:0] rem_q;
  logic        neg_q, neg_rem_q, div0_q, ovf_q;
  logic [31:0] a_orig_q;
  logic [4:0]  rd_pend_q;
  logic        busy_q, done_q, wb_we_q;
  logic [31:0] result_q;
  logic [4:0]  rd_q;

  logic        a_sgn, b_sgn, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  always_comb begin
    a_sgn = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_sgn = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    a_neg = a_sgn & a[31];
    b_neg = b_sgn & b[31];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // Multiply keeps the multiplier in acc_q[31:0] and shifts the product in from
  // the top; divide keeps the dividend there and shifts quotient bits in below.
  logic [32:0] add_sum;
  logic [32:0] shifted;
  logic [33:0] diff;
  logic [63:0] acc_d;
  logic [32:0] rem_d;

  always_comb begin
    add_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    shifted = {rem_q[31:0], acc_q[31]};
    diff    = {1'b0, shifted} - {2'b00, opnd_q};
    acc_d   = acc_q;
    rem_d   = rem_q;
    if (op_q[2]) begin
      if (!diff[33]) begin
        rem_d = diff[32:0];
        acc_d = {acc_q[63:32], acc_q[30:0], 1'b1};
      end else begin
        rem_d = shifted;
        acc_d = {acc_q[63:32], acc_q[30:0], 1'b0};
      end
    end else begin
      acc_d = {add_sum, acc_q[31:1]};
    end
  end

  logic [63:0] prod_s;
  logic [31:0] quo_s, rem_s, fin;

  always_comb begin
    prod_s = neg_q ? -acc_d : acc_d;
    quo_s  = neg_q ? -acc_d[31:0] : acc_d[31:0];
    rem_s  = neg_rem_q ? -rem_d[31:0] : rem_d[31:0];
    case (op_q)
      3'b000:                fin = prod_s[31:0];
      3'b001, 3'b010, 3'b011: fin = prod_s[63:32];
      3'b100, 3'b101:        fin = div0_q ? 32'hFFFF_FFFF : (ovf_q ? 32'h8000_0000 : quo_s);
      default:               fin = div0_q ? a_orig_q : (ovf_q ? 32'h0000_0000 : rem_s);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      op_q      <= 3'd0;
      opnd_q    <= 32'd0;
      acc_q     <= 64'd0;
      rem_q     <= 33'd0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      a_orig_q  <= 32'd0;
      rd_pend_q <= 5'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wb_we_q   <= 1'b0;
      result_q  <= 32'd0;
      rd_q      <= 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_CALC;
            busy_q    <= 1'b1;
            cnt_q     <= 5'd0;
            op_q      <= op;
            opnd_q    <= op[2] ? b_mag : a_mag;
            acc_q     <= op[2] ? {32'd0, a_mag} : {32'd0, b_mag};
            rem_q     <= 33'd0;
            neg_q     <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            div0_q    <= (b == 32'd0);
            ovf_q     <= ((op == 3'b100) || (op == 3'b110)) &&
                         (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
            a_orig_q  <= a;
            rd_pend_q <= rd_in;
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            result_q <= fin;
            rd_q     <= rd_pend_q;
            wb_we_q  <= (rd_pend_q != 5'd0);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          wb_we_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_q;
  assign wb_we  = wb_we_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed RV32M results, fixed latency,
// handshake corners and asynchronous abort.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [4:0]  rd_in;
  logic        busy, done, wb_we;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out),
    .wb_we  (wb_we)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Run one op to completion; inject_at >= 0 pulses a competing start mid-CALC.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] aa,
                       input logic [31:0] bb, input logic [4:0] rr,
                       input logic [31:0] exp, input int inject_at);
    int   lat;
    logic busy_ok;
    op = o; a = aa; b = bb; rd_in = rr; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; a = ~aa; b = bb ^ 32'h5A5A_5A5A; rd_in = ~rr;
    check({tag, " busy_start"}, 32'(busy), 32'd1);
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (lat == inject_at) begin
        start = 1'b1; op = 3'b000; a = 32'd9; b = 32'd9; rd_in = 5'd9;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (!busy) busy_ok = 1'b0;
    end
    start = 1'b0;
    $display("op %s: result=0x%08h rd_out=%0d wb_we=%0d latency=%0d", tag, result, rd_out, wb_we, lat);
    check({tag, " latency"}, 32'(lat), 32'd32);
    check({tag, " busy_hold"}, 32'(busy_ok), 32'd1);
    check({tag, " result"}, result, exp);
    check({tag, " rd_out"}, 32'(rd_out), 32'(rr));
    check({tag, " wb_we"}, 32'(wb_we), 32'(rr != 5'd0));
    @(posedge clk); #1;
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int   lat;
    logic seen;
    rst = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; rd_in = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst wb_we", 32'(wb_we), 32'd0);
    check("rst result", result, 32'd0);
    check("rst rd_out", 32'(rd_out), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op("mul_7x6",     3'b000, 32'd7,          32'd6,          5'd5,  32'd42,         -1);
    do_op("mulh_m1",     3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'h0000_0000,  -1);
    do_op("mulhu_max",   3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFE,  -1);
    do_op("mulhsu_max",  3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd3,  32'hFFFF_FFFF,  -1);
    do_op("mul_wrap",    3'b000, 32'h8000_0000,  32'd2,          5'd4,  32'h0000_0000,  -1);
    do_op("div_m7_2",    3'b100, 32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFD,  -1);
    do_op("rem_m7_2",    3'b110, 32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFF,  -1);
    do_op("div_7_m2",    3'b100, 32'd7,          32'hFFFF_FFFE,  5'd8,  32'hFFFF_FFFD,  -1);
    do_op("rem_7_m2",    3'b110, 32'd7,          32'hFFFF_FFFE,  5'd9,  32'd1,          -1);
    do_op("divu_100_7",  3'b101, 32'd100,        32'd7,          5'd10, 32'd14,         -1);
    do_op("remu_100_7",  3'b111, 32'd100,        32'd7,          5'd11, 32'd2,          -1);
    do_op("div_by0",     3'b100, 32'd5,          32'd0,          5'd12, 32'hFFFF_FFFF,  -1);
    do_op("remu_by0",    3'b111, 32'd5,          32'd0,          5'd13, 32'd5,          -1);
    do_op("rem_neg_by0", 3'b110, 32'hFFFF_FFF9,  32'd0,          5'd14, 32'hFFFF_FFF9,  -1);
    do_op("div_ovf",     3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd15, 32'h8000_0000,  -1);
    do_op("rem_ovf",     3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd16, 32'd0,          -1);
    do_op("ignore_start",3'b000, 32'd7,          32'd6,          5'd5,  32'd42,         10);
    do_op("rd_zero",     3'b000, 32'd11,         32'd3,          5'd0,  32'd33,         -1);

    // start held high: second op is taken only once the unit is back in IDLE
    op = 3'b101; a = 32'd100; b = 32'd7; rd_in = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("op held_first: result=0x%08h rd_out=%0d latency=%0d", result, rd_out, lat);
    check("held_first latency", 32'(lat), 32'd32);
    check("held_first result", result, 32'd14);
    op = 3'b000; a = 32'd3; b = 32'd5; rd_in = 5'd4;
    @(posedge clk); #1;
    check("held idle_gap busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("held accept busy", 32'(busy), 32'd1);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("op held_second: result=0x%08h rd_out=%0d latency=%0d", result, rd_out, lat);
    check("held_second latency", 32'(lat), 32'd32);
    check("held_second result", result, 32'd15);
    check("held_second rd_out", 32'(rd_out), 32'd4);
    @(posedge clk); #1;

    // asynchronous abort in the middle of CALC
    op = 3'b000; a = 32'd7; b = 32'd6; rd_in = 5'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    $display("op reset_abort: busy=%0d done=%0d result=0x%08h rd_out=%0d", busy, done, result, rd_out);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort wb_we", 32'(wb_we), 32'd0);
    check("abort result", result, 32'd0);
    check("abort rd_out", 32'(rd_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("abort no_done", 32'(seen), 32'd0);
    do_op("mul_after_rst", 3'b000, 32'd3, 32'd4, 5'd7, 32'd12, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
